// File: rtl/pcie_tx_sched.sv
// Transmit-side link scheduler: 8-cycle frames, COM training until the receiver
// aligns, then round-robin sharing of the lanes between two requesters with IDL fill.
module pcie_tx_sched #(
  parameter int unsigned TRAIN_FRAMES = 4,
  parameter logic [7:0]  COM          = 8'hBC,
  parameter logic [7:0]  IDL          = 8'h7C
) (
  input  logic        IN_CLK_2MHz,
  input  logic        IN_RESET,
  input  logic        IN_ENB,
  input  logic        IN_LINK_OK,
  input  logic        IN_REQ0,
  input  logic [31:0] IN_DATA0,
  input  logic        IN_REQ1,
  input  logic [31:0] IN_DATA1,
  output logic        OUT_GNT0,
  output logic        OUT_GNT1,
  output logic [7:0]  OUT_LANE3,
  output logic [7:0]  OUT_LANE2,
  output logic [7:0]  OUT_LANE1,
  output logic [7:0]  OUT_LANE0,
  output logic        OUT_VALID_TX,
  output logic        OUT_FRAME,
  output logic [1:0]  OUT_STATE
);

  typedef enum logic [1:0] {
    RESET_ST = 2'b00,
    TRAIN    = 2'b01,
    ACTIVE   = 2'b10
  } state_t;

  localparam logic [3:0] TRAIN_MAX = 4'(TRAIN_FRAMES);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [3:0]  train_cnt_q, train_cnt_d;
  logic        ptr_q, ptr_d;
  logic [31:0] lanes_q, lanes_d;
  logic        valid_q, valid_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        frame_q;
  logic        boundary;
  logic        serve;
  logic        pick0, pick1;

  assign boundary = IN_ENB && (cnt_q == 3'd7);

  // Requester 1 wins when it asks alone, or when both ask and the pointer favours it.
  assign pick1 = IN_REQ1 && (!IN_REQ0 || ptr_q);
  assign pick0 = IN_REQ0 && !pick1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    ptr_d       = ptr_q;
    lanes_d     = lanes_q;
    valid_d     = valid_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    serve       = 1'b0;

    if (boundary) begin
      unique case (state_q)
        // The COM frame loaded when leaving RESET_ST counts as the first training frame.
        RESET_ST: begin
          state_d     = TRAIN;
          train_cnt_d = 4'd1;
        end
        TRAIN: begin
          if (train_cnt_q >= TRAIN_MAX && IN_LINK_OK) begin
            state_d = ACTIVE;
            serve   = 1'b1;
          end else if (train_cnt_q < TRAIN_MAX) begin
            train_cnt_d = train_cnt_q + 4'd1;
          end
        end
        ACTIVE: begin
          if (!IN_LINK_OK) begin
            state_d     = TRAIN;
            train_cnt_d = '0;
          end else begin
            serve = 1'b1;
          end
        end
        default: state_d = RESET_ST;
      endcase

      if (!serve) begin
        lanes_d = {4{COM}};
        valid_d = 1'b0;
      end else if (pick0) begin
        lanes_d = IN_DATA0;
        valid_d = 1'b1;
        gnt0_d  = 1'b1;
        ptr_d   = 1'b1;
      end else if (pick1) begin
        lanes_d = IN_DATA1;
        valid_d = 1'b1;
        gnt1_d  = 1'b1;
        ptr_d   = 1'b0;
      end else begin
        lanes_d = {4{IDL}};
        valid_d = 1'b0;
      end
    end
  end

  // Every *_d defaults to hold and boundary needs IN_ENB, so a low enable freezes
  // the frame state while the one-cycle strobes fall back to zero.
  always_ff @(posedge IN_CLK_2MHz or negedge IN_RESET) begin
    if (!IN_RESET) begin
      cnt_q       <= '0;
      state_q     <= RESET_ST;
      train_cnt_q <= '0;
      ptr_q       <= 1'b0;
      lanes_q     <= '0;
      valid_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values.
      if (IN_ENB) cnt_q <= cnt_q + 3'd1;
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      ptr_q       <= ptr_d;
      lanes_q     <= lanes_d;
      valid_q     <= valid_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      frame_q     <= boundary;
    end
  end

  assign OUT_LANE3    = lanes_q[31:24];
  assign OUT_LANE2    = lanes_q[23:16];
  assign OUT_LANE1    = lanes_q[15:8];
  assign OUT_LANE0    = lanes_q[7:0];
  assign OUT_VALID_TX = valid_q;
  assign OUT_GNT0     = gnt0_q;
  assign OUT_GNT1     = gnt1_q;
  assign OUT_FRAME    = frame_q;
  assign OUT_STATE    = state_q;

endmodule

// File: tb/tb_pcie_tx_sched.sv
// Scoreboard bench for pcie_tx_sched: a frame-level reference model queues the
// expected word per boundary, a monitor pops and compares whenever a frame strobes.
`timescale 1ns/1ps
module tb_pcie_tx_sched;

  localparam int         TF  = 4;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enb = 1'b0;
  logic        link_ok = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic        gnt0, gnt1, valid_tx, frame;
  logic [7:0]  lane3, lane2, lane1, lane0;
  logic [1:0]  state;

  always #250 clk = ~clk;

  pcie_tx_sched #(.TRAIN_FRAMES(TF), .COM(COM), .IDL(IDL)) dut (
    .IN_CLK_2MHz (clk),
    .IN_RESET    (rst_n),
    .IN_ENB      (enb),
    .IN_LINK_OK  (link_ok),
    .IN_REQ0     (req0),
    .IN_DATA0    (data0),
    .IN_REQ1     (req1),
    .IN_DATA1    (data1),
    .OUT_GNT0    (gnt0),
    .OUT_GNT1    (gnt1),
    .OUT_LANE3   (lane3),
    .OUT_LANE2   (lane2),
    .OUT_LANE1   (lane1),
    .OUT_LANE0   (lane0),
    .OUT_VALID_TX(valid_tx),
    .OUT_FRAME   (frame),
    .OUT_STATE   (state)
  );

  typedef struct packed {
    logic [31:0] word;
    logic        valid;
    logic        gnt0;
    logic        gnt1;
    logic [1:0]  state;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: position within the frame, link phase (0 reset, 1 train,
  // 2 active), COM frames counted toward training, and who is preferred next.
  int m_pos = 0, m_phase = 0, m_com = 0, m_pref = 0;

  task automatic model_boundary();
    exp_t e;
    int   winner;
    case (m_phase)
      0: begin m_phase = 1; m_com = 1; end
      1: begin
        if (m_com >= TF && link_ok) m_phase = 2;
        else if (m_com < TF) m_com++;
      end
      default: if (!link_ok) begin m_phase = 1; m_com = 0; end
    endcase
    e = '{word: {4{COM}}, valid: 1'b0, gnt0: 1'b0, gnt1: 1'b0, state: 2'(m_phase)};
    if (m_phase == 2) begin
      winner = (req0 && req1) ? m_pref : req0 ? 0 : req1 ? 1 : -1;
      if (winner < 0) begin
        e.word = {4{IDL}};
      end else begin
        e.word  = (winner == 0) ? data0 : data1;
        e.valid = 1'b1;
        e.gnt0  = (winner == 0);
        e.gnt1  = (winner == 1);
        m_pref  = 1 - winner;
      end
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pos = 0; m_phase = 0; m_com = 0; m_pref = 0;
      exp_q.delete();
    end else if (enb) begin
      if (m_pos == 7) model_boundary();
      m_pos = (m_pos + 1) % 8;
    end
  end

  // Monitor: lanes must hold the last popped word between strobes.
  initial begin : monitor
    exp_t e;
    exp_t hold;
    hold = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) hold = '0;
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        hold = e;
        check("frame strobe", frame, 1'b1);
        check("grants", {gnt1, gnt0}, {e.gnt1, e.gnt0});
      end else begin
        check("no strobe", frame, 1'b0);
        check("no grant", {gnt1, gnt0}, 2'b00);
      end
      check("lanes", {lane3, lane2, lane1, lane0}, hold.word);
      check("valid", valid_tx, hold.valid);
      check("state", state, hold.state);
    end
  end

  task automatic wait_grant(input int bound, output int who);
    who = -1;
    for (int i = 0; i < bound && who < 0; i++) begin
      @(negedge clk);
      if (gnt0) who = 0;
      else if (gnt1) who = 1;
    end
  endtask

  task automatic wait_frame(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40 && cycles < 0; i++) begin
      @(negedge clk);
      if (frame) cycles = i;
    end
    if (cycles < 0) check("frame timeout", 0, 1);
  endtask

  initial begin
    int who, cyc, com_frames;
    bit got;

    // Reset, then training with link already up.
    enb = 1'b1; link_ok = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    check("no frame before 8 cycles", frame, 1'b0);
    @(negedge clk);
    check("first frame at 8 cycles", frame, 1'b1);
    check("first frame in TRAIN", state, 2'b01);
    check("first frame COM", {lane3, lane2, lane1, lane0}, {4{COM}});
    repeat (32) @(negedge clk);
    check("frame 5 ACTIVE", state, 2'b10);
    check("frame 5 IDL", {lane3, lane2, lane1, lane0}, {4{IDL}});

    // Contention: both held high alternate, starting with requester 0.
    req0 = 1'b1; data0 = 32'h1111_1111;
    req1 = 1'b1; data1 = 32'h2222_2222;
    for (int k = 0; k < 4; k++) begin
      wait_grant(16, who);
      check("alternating grant", who, k % 2);
      check("alternating word", {lane3, lane2, lane1, lane0}, (k % 2) ? data1 : data0);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) @(negedge clk);

    // Single uncontested request.
    req0 = 1'b1; data0 = 32'hDEAD_BEEF;
    wait_grant(8, who);
    check("DEADBEEF grant", who, 0);
    check("DEADBEEF lanes", {lane3, lane2, lane1, lane0}, 32'hDEAD_BEEF);
    req0 = 1'b0;
    repeat (8) @(negedge clk);
    check("IDL after drop", {lane3, lane2, lane1, lane0}, {4{IDL}});

    // Link loss coincident with a request: retrain first, then grant.
    wait_frame(cyc);
    req1 = 1'b1; data1 = 32'hCAFE_F00D; link_ok = 1'b0;
    wait_frame(cyc);
    check("link loss state", state, 2'b01);
    check("link loss no grant", gnt1, 1'b0);
    link_ok = 1'b1;
    got = 1'b0; com_frames = 0;
    for (int f = 0; f < 8 && !got; f++) begin
      wait_frame(cyc);
      if (gnt1) got = 1'b1;
      else com_frames++;
    end
    check("grant after relink", got, 1'b1);
    check("COM frames before regrant", com_frames, 4);
    check("relink data", {lane3, lane2, lane1, lane0}, 32'hCAFE_F00D);
    req1 = 1'b0;

    // Enable low for 5 cycles mid-frame stretches the frame by 5.
    wait_frame(cyc);
    repeat (3) @(negedge clk);
    enb = 1'b0;
    repeat (5) @(negedge clk);
    enb = 1'b1;
    wait_frame(cyc);
    check("stretched frame period", cyc + 8, 13);

    // Reset in the middle of a granted data frame.
    req0 = 1'b1; data0 = 32'hA5A5_5A5A;
    wait_grant(16, who);
    check("pre-reset grant", who, 0);
    #100;
    rst_n = 1'b0;
    #1;
    check("async reset lanes", {lane3, lane2, lane1, lane0}, 32'h0);
    check("async reset valid", valid_tx, 1'b0);
    check("async reset state", state, 2'b00);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_frame(cyc);
    check("frame 8 cycles after release", cyc, 8);
    check("retrain after reset", state, 2'b01);

    // Randomized traffic, link drops and enable gaps.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (req0) begin
        if (gnt0) begin
          if ($urandom_range(1) == 1) data0 = $urandom;
          else req0 = 1'b0;
        end else if ($urandom_range(40) == 0) begin
          req0 = 1'b0;
        end
      end else if ($urandom_range(3) == 0) begin
        req0 = 1'b1; data0 = $urandom;
      end
      if (req1) begin
        if (gnt1) begin
          if ($urandom_range(1) == 1) data1 = $urandom;
          else req1 = 1'b0;
        end else if ($urandom_range(40) == 0) begin
          req1 = 1'b0;
        end
      end else if ($urandom_range(3) == 0) begin
        req1 = 1'b1; data1 = $urandom;
      end
      if (link_ok && $urandom_range(150) == 0) link_ok = 1'b0;
      else if (!link_ok && $urandom_range(20) == 0) link_ok = 1'b1;
      if (enb && !frame && $urandom_range(40) == 0) enb = 1'b0;
      else if (!enb && $urandom_range(3) == 0) enb = 1'b1;
    end

    req0 = 1'b0; req1 = 1'b0; enb = 1'b1; link_ok = 1'b1;
    repeat (40) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(500.0 * 50000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pcie_tx_sched.md
# pcie_tx_sched

Transmit-side link scheduler for the 4-lane PCIe-style parallel-to-serial/serial-to-parallel link. Runs on the 2 MHz bit clock and cuts it into 8-cycle frames, one 32-bit word per frame, matching the 250 KHz word rate of the serializer. It holds the link in a COM training pattern until the receiver reports alignment. It then shares the transmitter between two requesters by round-robin and emits IDL filler when neither is requesting. Its outputs drive the transmitter's lane inputs and valid input directly.

## Interface

- TRAIN_FRAMES, 4: minimum number of COM frames sent before ACTIVE may be entered (1..15).
- COM, 8'hBC: training symbol, placed on every lane.
- IDL, 8'h7C: idle symbol, placed on every lane.

- IN_CLK_2MHz  in  1  bit clock; all logic on rising edge.
- IN_RESET  in  1  asynchronous, active-low reset.
- IN_ENB  in  1  enable; low freezes all state and outputs.
- IN_LINK_OK  in  1  receiver alignment flag, synchronous to IN_CLK_2MHz.
- IN_REQ0  in  1  requester 0 request.
- IN_DATA0  in  32  requester 0 word; [31:24] goes to lane 3, [7:0] to lane 0.
- IN_REQ1  in  1  requester 1 request.
- IN_DATA1  in  32  requester 1 word; same lane mapping as IN_DATA0.
- OUT_GNT0  out  1  one-cycle grant to requester 0.
- OUT_GNT1  out  1  one-cycle grant to requester 1.
- OUT_LANE3  out  8  lane 3 byte.
- OUT_LANE2  out  8  lane 2 byte.
- OUT_LANE1  out  8  lane 1 byte.
- OUT_LANE0  out  8  lane 0 byte.
- OUT_VALID_TX  out  1  high when the lanes carry requester data.
- OUT_FRAME  out  1  one-cycle strobe marking a new word on the lanes.
- OUT_STATE  out  2  current state: 00 RESET_ST, 01 TRAIN, 10 ACTIVE.

## Operation

- Frame counter cnt[2:0] increments on each clock edge with IN_ENB=1 and wraps 7→0.
- A boundary is the cycle with cnt==7 and IN_ENB=1. All decisions, sampling of IN_LINK_OK, IN_REQx and IN_DATAx, and output loads happen at that edge.
- Reset (IN_RESET=0), applied immediately and asynchronously:
  - cnt=0, train_cnt=0, state RESET_ST, RR pointer = requester 0.
  - All OUT_LANEx=8'h00, OUT_VALID_TX=0, OUT_GNT0/1=0, OUT_FRAME=0.
- RESET_ST: at the first boundary, go to TRAIN and load COM on all lanes.
- TRAIN:
  - Each boundary loads COM on all lanes with VALID=0.
  - train_cnt increments and saturates at TRAIN_FRAMES.
  - Go to ACTIVE at a boundary where train_cnt==TRAIN_FRAMES (before the increment) and IN_LINK_OK=1. That boundary already loads ACTIVE content (data or IDL).
  - No grants are issued in TRAIN.
- ACTIVE, at each boundary:
  - If IN_LINK_OK=0: go to TRAIN, clear train_cnt, load COM, issue no grant, keep the pointer.
  - Else if only one IN_REQx=1: grant that requester.
  - Else if both are 1: grant the requester the pointer selects.
  - A grant loads IN_DATAx onto the lanes, sets VALID=1 and pulses OUT_GNTx. The pointer then moves to the other requester.
  - Else (no request): load IDL on all lanes with VALID=0; the pointer is unchanged.
- Requester rules:
  - Hold IN_REQx and IN_DATAx stable until OUT_GNTx.
  - Deasserting REQ before the grant withdraws the request; no grant is issued for it.
  - A requester that still has REQ high on the cycle after its GNT is treated as a new request.
- IN_ENB=0: cnt, state, train_cnt, pointer and lanes hold. OUT_GNTx and OUT_FRAME are forced to 0.

## Timing

- Lanes, VALID, OUT_STATE, OUT_GNTx and OUT_FRAME are all registered and change on the boundary edge.
- OUT_GNTx and OUT_FRAME are high for exactly one cycle, coincident with the new word's first cycle.
- With IN_ENB held high, OUT_FRAME occurs once every 8 cycles. The first OUT_FRAME after reset release occurs 8 cycles after release.
- Lanes hold their value for the whole 8-cycle frame.
- Grant latency from IN_REQx rising: at most 8 enabled cycles when uncontested; at most 16 when contested.
- Simultaneous link loss and request: link loss wins, and the request stays pending.
- Reset asserted mid-frame clears outputs immediately; the frame in progress is abandoned.

## Test plan

- Reset, ENB=1, LINK_OK=1 from start → frame 1 enters TRAIN (OUT_STATE=01); 4 COM frames with lanes=BC, VALID=0; frame 5 enters ACTIVE (OUT_STATE=10) with lanes=7C, OUT_FRAME every 8 cycles.
- ACTIVE, REQ0=1, DATA0=32'hDEADBEEF → at the next boundary GNT0 pulses once; LANE3..0=DE,AD,BE,EF; VALID=1 for 8 cycles; then 7C if REQ0 has dropped.
- ACTIVE, REQ0 and REQ1 held high, DATA0=32'h11111111, DATA1=32'h22222222 → frames alternate 11,22,11,22 starting with requester 0; GNT0 and GNT1 alternate.
- ACTIVE, LINK_OK dropped with REQ1 pending → next frame is COM (BC) in TRAIN with no GNT1; LINK_OK restored → after 4 more COM frames, DATA1 is granted.
- IN_ENB low for 5 cycles mid-frame → lanes and cnt frozen; the next OUT_FRAME is delayed by exactly 5 cycles.
- IN_RESET pulsed low during a granted data frame → lanes go to 00 and VALID to 0 asynchronously; the training sequence restarts after release.
